// File: rtl/sent_tx_pulse_gen.sv
// SENT transmit pulse encoder: sync, status, data and CRC pulses on a single idle-high line.
// Optional SENT_TX_PAUSE_EN appends a pause pulse so every frame lasts FRAME_TICKS ticks.
module sent_tx_pulse_gen #(
    parameter int DIV         = 4,
    parameter int LOW_TICKS   = 5,
    parameter int SYNC_TICKS  = 56,
    parameter int FRAME_TICKS = 282
) (
    input  logic        clk_tx,
    input  logic        reset_tx,
    input  logic        frame_valid,
    output logic        frame_ready,
    input  logic [3:0]  status_nibble,
    input  logic [23:0] data_nibbles,
    input  logic [2:0]  num_nibbles,
    input  logic [3:0]  crc_nibble,
    output logic        data_pulse,
    output logic        busy,
    output logic [2:0]  nibble_index,
    output logic        done_frame
);

    localparam int              PW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   LP_DIV_M1 = PW'(DIV - 1);
    localparam logic [11:0]     LP_LOW    = 12'(LOW_TICKS);
    localparam logic [11:0]     LP_SYNC   = 12'(SYNC_TICKS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SYNC   = 3'd1,
        S_STATUS = 3'd2,
        S_DATA   = 3'd3,
        S_CRC    = 3'd4
`ifdef SENT_TX_PAUSE_EN
        , S_PAUSE = 3'd5
`endif
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [PW-1:0] r_presc, w_presc_nxt;
    logic [11:0]   r_pcnt, w_pcnt_nxt;
    logic [2:0]    r_nib, w_nib_nxt;
    logic [3:0]    r_status, r_crc;
    logic [23:0]   r_data;
    logic [2:0]    r_num;
    logic          r_pulse, r_busy, r_ready, r_done;
    logic [2:0]    r_idx;
    logic          w_pulse_nxt, w_busy_nxt, w_done_nxt;
    logic [2:0]    w_idx_nxt, w_num_clamped;
    logic [11:0]   w_len;
    logic          w_tick, w_last, w_accept;

`ifdef SENT_TX_PAUSE_EN
    localparam logic [11:0] LP_FRAME = 12'(FRAME_TICKS);
    logic [11:0] r_len;
    logic [12:0] w_gap;
    logic [11:0] w_pause;
    // Pause fills the frame up to FRAME_TICKS, never shorter than 12 ticks.
    assign w_gap   = {1'b0, LP_FRAME} - {1'b0, r_len};
    assign w_pause = (w_gap[12] || (w_gap[11:0] < 12'd12)) ? 12'd12 : w_gap[11:0];
`endif

    assign w_num_clamped = (num_nibbles == 3'd0) ? 3'd1 :
                           ((num_nibbles > 3'd6) ? 3'd6 : num_nibbles);
    assign w_accept = (r_state == S_IDLE) && frame_valid;
    assign w_tick   = (r_presc == LP_DIV_M1);
    assign w_last   = w_tick && (r_pcnt == (w_len - 12'd1));

    // Length in ticks of the pulse currently being sent.
    always_comb begin
        case (r_state)
            S_SYNC:   w_len = LP_SYNC;
            S_STATUS: w_len = 12'd12 + {8'd0, r_status};
            S_DATA:   w_len = 12'd12 + {8'd0, r_data[23:20]};
            S_CRC:    w_len = 12'd12 + {8'd0, r_crc};
`ifdef SENT_TX_PAUSE_EN
            S_PAUSE:  w_len = w_pause;
`endif
            default:  w_len = LP_SYNC;
        endcase
    end

    // Next state, tick prescaler, pulse counter and data nibble position.
    always_comb begin
        w_state_nxt = r_state;
        w_nib_nxt   = r_nib;
        if (r_state == S_IDLE) begin
            w_presc_nxt = '0;
            w_pcnt_nxt  = 12'd0;
        end else begin
            w_presc_nxt = w_tick ? '0 : (r_presc + PW'(1));
            w_pcnt_nxt  = w_last ? 12'd0 : (w_tick ? (r_pcnt + 12'd1) : r_pcnt);
        end
        case (r_state)
            S_IDLE: begin
                if (frame_valid) w_state_nxt = S_SYNC;
                else             w_state_nxt = S_IDLE;
            end
            S_SYNC: begin
                if (w_last) w_state_nxt = S_STATUS;
                else        w_state_nxt = S_SYNC;
            end
            S_STATUS: begin
                if (w_last) begin
                    w_state_nxt = S_DATA;
                    w_nib_nxt   = 3'd1;
                end else begin
                    w_state_nxt = S_STATUS;
                end
            end
            S_DATA: begin
                if (w_last && (r_nib == r_num)) w_state_nxt = S_CRC;
                else if (w_last)                w_nib_nxt   = r_nib + 3'd1;
                else                            w_state_nxt = S_DATA;
            end
            S_CRC: begin
`ifdef SENT_TX_PAUSE_EN
                if (w_last) w_state_nxt = S_PAUSE;
`else
                if (w_last) w_state_nxt = S_IDLE;
`endif
                else        w_state_nxt = S_CRC;
            end
`ifdef SENT_TX_PAUSE_EN
            S_PAUSE: begin
                if (w_last) w_state_nxt = S_IDLE;
                else        w_state_nxt = S_PAUSE;
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output values for the next cycle, registered below.
    always_comb begin
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_done_nxt = (r_state != S_IDLE) && (w_state_nxt == S_IDLE);
        if (w_state_nxt == S_IDLE) w_pulse_nxt = 1'b1;
        else                       w_pulse_nxt = (w_pcnt_nxt >= LP_LOW);
        case (w_state_nxt)
            S_STATUS: w_idx_nxt = 3'd0;
            S_DATA:   w_idx_nxt = w_nib_nxt;
            default:  w_idx_nxt = 3'd7;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_tx or posedge reset_tx) begin
        if (reset_tx) begin
            r_state <= S_IDLE;
            r_presc <= '0;
            r_pcnt  <= 12'd0;
            r_nib   <= 3'd0;
            r_pulse <= 1'b1;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_idx   <= 3'd7;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_presc <= w_presc_nxt;
            r_pcnt  <= w_pcnt_nxt;
            r_nib   <= w_nib_nxt;
            r_pulse <= w_pulse_nxt;
            r_busy  <= w_busy_nxt;
            r_ready <= ~w_busy_nxt;
            r_idx   <= w_idx_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Frame fields latched on accept; data shifts so the current nibble sits at [23:20].
    always_ff @(posedge clk_tx or posedge reset_tx) begin
        if (reset_tx) begin
            r_status <= 4'd0;
            r_crc    <= 4'd0;
            r_data   <= 24'd0;
            r_num    <= 3'd0;
`ifdef SENT_TX_PAUSE_EN
            r_len    <= 12'd0;
`endif
        end else if (w_accept) begin
            r_status <= status_nibble;
            r_crc    <= crc_nibble;
            r_data   <= data_nibbles;
            r_num    <= w_num_clamped;
`ifdef SENT_TX_PAUSE_EN
            r_len    <= 12'd0;
`endif
        end else begin
            if (w_last && (r_state == S_DATA)) r_data <= {r_data[19:0], 4'd0};
`ifdef SENT_TX_PAUSE_EN
            if (w_last && (r_state != S_PAUSE)) r_len <= r_len + w_len;
`endif
        end
    end

    assign data_pulse   = r_pulse;
    assign busy         = r_busy;
    assign frame_ready  = r_ready;
    assign nibble_index = r_idx;
    assign done_frame   = r_done;

endmodule

// File: tb/tb_sent_tx_pulse_gen.sv
// Scoreboard bench for sent_tx_pulse_gen: a frame-level model queues expected pulse trains,
// a line monitor measures each pulse and compares on done_frame.
module tb_sent_tx_pulse_gen;

    localparam int DIV         = 4;
    localparam int LOW_TICKS   = 5;
    localparam int SYNC_TICKS  = 56;
    localparam int FRAME_TICKS = 282;

    logic        clk_tx = 1'b0;
    logic        reset_tx;
    logic        frame_valid;
    logic        frame_ready;
    logic [3:0]  status_nibble;
    logic [23:0] data_nibbles;
    logic [2:0]  num_nibbles;
    logic [3:0]  crc_nibble;
    logic        data_pulse;
    logic        busy;
    logic [2:0]  nibble_index;
    logic        done_frame;

    sent_tx_pulse_gen #(
        .DIV(DIV), .LOW_TICKS(LOW_TICKS), .SYNC_TICKS(SYNC_TICKS), .FRAME_TICKS(FRAME_TICKS)
    ) dut (
        .clk_tx(clk_tx), .reset_tx(reset_tx), .frame_valid(frame_valid), .frame_ready(frame_ready),
        .status_nibble(status_nibble), .data_nibbles(data_nibbles), .num_nibbles(num_nibbles),
        .crc_nibble(crc_nibble), .data_pulse(data_pulse), .busy(busy),
        .nibble_index(nibble_index), .done_frame(done_frame)
    );

    always #5 clk_tx = ~clk_tx;

    typedef struct {
        int n;
        int len [10];
        int idx [10];
    } exp_t;

    exp_t exp_q [$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input int act, input int expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    // Expected pulse train of one frame, straight from the protocol rules.
    function automatic exp_t model(input logic [3:0] s, input logic [23:0] d,
                                   input logic [2:0] n, input logic [3:0] c);
        exp_t e;
        int   nn;
        int   tot;
        int   v;
        nn  = (n == 3'd0) ? 1 : ((n > 3'd6) ? 6 : int'(n));
        e.n = 0;
        e.len[e.n] = SYNC_TICKS; e.idx[e.n] = 7; e.n++;
        e.len[e.n] = 12 + int'(s); e.idx[e.n] = 0; e.n++;
        for (int i = 0; i < nn; i++) begin
            v = int'((d >> (20 - 4 * i)) & 24'h00000F);
            e.len[e.n] = 12 + v; e.idx[e.n] = i + 1; e.n++;
        end
        e.len[e.n] = 12 + int'(c); e.idx[e.n] = 7; e.n++;
`ifdef SENT_TX_PAUSE_EN
        tot = 0;
        for (int i = 0; i < e.n; i++) tot += e.len[i];
        v = FRAME_TICKS - tot;
        if (v < 12) v = 12;
        e.len[e.n] = v; e.idx[e.n] = 7; e.n++;
`else
        tot = 0;
`endif
        return e;
    endfunction

    // Monitor: measures pulses on the line and checks them against the queue at frame end.
    int   cyc = 0;
    logic prev_dp = 1'b1;
    bit   acc_pend = 1'b0;
    int   np = 0;
    int   st [16];
    int   lo [16];
    int   ix [16];
    always @(negedge clk_tx) begin
        exp_t e;
        int   end_t;
        cyc++;
        if (reset_tx) begin
            np       = 0;
            acc_pend = 1'b0;
            prev_dp  = 1'b1;
        end else begin
            if (acc_pend) begin
                chk("start_low", int'(data_pulse), 0);
                chk("start_busy", int'(busy), 1);
                chk("start_ready", int'(frame_ready), 0);
            end
            acc_pend = frame_valid && frame_ready;
            if (prev_dp && !data_pulse) begin
                if (np < 16) begin
                    st[np] = cyc; ix[np] = int'(nibble_index); lo[np] = -1;
                end
                np++;
            end else if (!prev_dp && data_pulse && np > 0 && np <= 16) begin
                lo[np-1] = cyc - st[np-1];
            end
            if (done_frame) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_count", np, e.n);
                    for (int i = 0; i < e.n && i < np && i < 16; i++) begin
                        end_t = (i + 1 < np) ? st[i+1] : cyc;
                        chk($sformatf("pulse_len[%0d]", i), end_t - st[i], e.len[i] * DIV);
                        chk($sformatf("pulse_low[%0d]", i), lo[i], LOW_TICKS * DIV);
                        chk($sformatf("nibble_index[%0d]", i), ix[i], e.idx[i]);
                    end
                    chk("done_line_high", int'(data_pulse), 1);
                    chk("done_busy", int'(busy), 0);
                    chk("done_ready", int'(frame_ready), 1);
                end
                np = 0;
            end
            prev_dp = data_pulse;
        end
    end

    // Present a frame and hold it until accepted; frame_valid is left high.
    task automatic issue(input logic [3:0] s, input logic [23:0] d,
                         input logic [2:0] n, input logic [3:0] c);
        bit acc;
        acc = 1'b0;
        status_nibble = s; data_nibbles = d; num_nibbles = n; crc_nibble = c;
        frame_valid = 1'b1;
        for (int k = 0; k < 5000 && !acc; k++) begin
            @(negedge clk_tx);
            acc = frame_ready;
            @(posedge clk_tx);
            #1;
        end
        if (acc) exp_q.push_back(model(s, d, n, c));
        else     chk("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        frame_valid = 1'b0;
        for (int k = 0; k < 20000 && !ok; k++) begin
            @(negedge clk_tx);
            if (exp_q.size() == 0 && !busy) ok = 1'b1;
        end
        if (!ok) chk("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        int   changes;
        int   seen;
        exp_t dump;
        reset_tx = 1'b1; frame_valid = 1'b0;
        status_nibble = 4'd0; data_nibbles = 24'd0; num_nibbles = 3'd0; crc_nibble = 4'd0;
        repeat (3) @(negedge clk_tx);
        chk("rst_data_pulse", int'(data_pulse), 1);
        chk("rst_ready", int'(frame_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_index", int'(nibble_index), 7);
        chk("rst_done", int'(done_frame), 0);
        #3 reset_tx = 1'b0;

        changes = 0;
        repeat (1000) begin
            @(negedge clk_tx);
            if (data_pulse !== 1'b1 || frame_ready !== 1'b1 || busy !== 1'b0 ||
                nibble_index !== 3'd7 || done_frame !== 1'b0) changes++;
        end
        chk("idle_stable", changes, 0);

        @(posedge clk_tx); #1;
        issue(4'h0, 24'h000000, 3'd6, 4'h0);
        frame_valid = 1'b0;
        drain();
        @(posedge clk_tx); #1;
        issue(4'hF, 24'hA00000, 3'd1, 4'h5);
        frame_valid = 1'b0;
        drain();
        @(posedge clk_tx); #1;
        issue(4'hF, 24'hFFFFFF, 3'd6, 4'hF);
        frame_valid = 1'b0;
        drain();

        // Back-to-back with frame_valid held; n=0 and n=7 exercise clamping.
        @(posedge clk_tx); #1;
        issue(4'h3, 24'h7BCDEF, 3'd0, 4'h9);
        issue(4'hC, 24'h123456, 3'd7, 4'h1);
        issue(4'h5, 24'h9E0000, 3'd2, 4'hE);
        drain();

        for (int r = 0; r < 18; r++) begin
            @(posedge clk_tx); #1;
            issue(4'($urandom_range(0, 15)), 24'($urandom), 3'($urandom_range(0, 7)),
                  4'($urandom_range(0, 15)));
            if ($urandom_range(0, 1) == 0) begin
                frame_valid = 1'b0;
                repeat ($urandom_range(0, 5)) @(posedge clk_tx);
                #1;
            end
        end
        drain();

        // Reset in the middle of the status pulse discards the frame.
        @(posedge clk_tx); #1;
        issue(4'h8, 24'h444444, 3'd4, 4'h2);
        frame_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 2000 && seen == 0; k++) begin
            @(negedge clk_tx);
            if (busy && nibble_index == 3'd0) seen = 1;
        end
        chk("reached_status", seen, 1);
        repeat (10) @(negedge clk_tx);
        #2 reset_tx = 1'b1;
        #1;
        chk("async_rst_line", int'(data_pulse), 1);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_ready", int'(frame_ready), 1);
        if (exp_q.size() > 0) dump = exp_q.pop_front();
        @(negedge clk_tx);
        #3 reset_tx = 1'b0;
        changes = 0;
        repeat (400) begin
            @(negedge clk_tx);
            if (done_frame !== 1'b0 || data_pulse !== 1'b1) changes++;
        end
        chk("post_rst_quiet", changes, 0);
        chk("post_rst_ready", int'(frame_ready), 1);

        @(posedge clk_tx); #1;
        issue(4'h1, 24'h2468AC, 3'd6, 4'h7);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
